// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int IFU_PC_W  = 9;
    localparam int IFU_INS_W = 32;
    localparam int IFU_DEPTH = 4;

    // Byte distance between consecutive 32-bit instructions.
    localparam int PC_STEP = 4;

    // Bubble presented to decode when no instruction is available.
    localparam logic [IFU_INS_W-1:0] IFU_NOP = 32'h0;

    // One queued fetch result: the PC it was fetched from and the word returned.
    typedef struct packed {
        logic [IFU_PC_W-1:0]  pc;
        logic [IFU_INS_W-1:0] instr;
    } fetch_entry_t;

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer holding fetched {pc, instr} entries for decode.
// Flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter  int WIDTH = $bits(fetch_entry_t),
    parameter  int DEPTH = IFU_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Writes to a full buffer and reads from an empty one are ignored.
    assign do_push = push && !flush && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop  && !flush && (count_q != '0);

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage.
    // NOTE: the storage array has no reset; count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign count = count_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues synchronous
// instruction-memory reads, queues returned words and presents the head to decode.
// Optional build macro IFU_STATS_EN adds saturating fetched/flushed counters.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int PC_W  = IFU_PC_W,
    parameter int INS_W = IFU_INS_W,
    parameter int DEPTH = IFU_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
`ifdef IFU_STATS_EN
    output logic [15:0]      fetched_cnt,
    output logic [15:0]      flushed_cnt,
`endif
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             stall,
    output logic             id_valid,
    output logic [PC_W-1:0]  id_pc,
    output logic [INS_W-1:0] id_instr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  inflight_pc;
    logic             inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             fifo_push;
    logic             fifo_pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // Queued entries plus the one response that may still be on its way.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);

    // Issue only while the queue can absorb the response; a redirect cancels
    // this cycle's fetch. Gating with reset keeps the request low while held in reset.
    assign imem_req  = reset && (occupancy < (CNT_W + 1)'(DEPTH)) && !redirect;
    assign imem_addr = fetch_pc;

    // A redirect drops both the response arriving now and the head being consumed.
    assign fifo_push = inflight && !redirect;
    assign fifo_pop  = id_valid && !stall && !redirect;

    assign push_entry = '{pc: inflight_pc, instr: imem_rdata};

    // Fetch PC and in-flight tracking; a redirect outranks a normal issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else if (imem_req) begin
            fetch_pc    <= fetch_pc + PC_W'(PC_STEP);
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect),
        .count     (fifo_count),
        .head      (head_entry)
    );

    // Decode sees the head entry, or a zero bubble when the queue is empty.
    assign id_valid = (fifo_count != '0);
    assign id_pc    = id_valid ? head_entry.pc    : '0;
    assign id_instr = id_valid ? head_entry.instr : IFU_NOP;

`ifdef IFU_STATS_EN
    // Count pushed instructions and entries discarded by redirects, saturating at 0xFFFF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetched_cnt <= '0;
            flushed_cnt <= '0;
        end else begin
            if (fifo_push) fetched_cnt <= sat_add16(fetched_cnt, 16'd1);
            if (redirect)  flushed_cnt <= sat_add16(flushed_cnt, 16'(occupancy));
        end
    end
`endif

endmodule
